// File: rtl/pulse_train_gen.sv
// Multi-channel pulse-train generator: emits a burst of fixed-width pulses on the
// masked channels with a programmable period and pulse count.
module pulse_train_gen #(
    parameter int unsigned CH    = 32,
    parameter int unsigned CNT_W = 22,
    parameter int unsigned NUM_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CH-1:0]    i_chan_mask,
    input  logic [CNT_W-1:0] i_pulse_width,
    input  logic [CNT_W-1:0] i_pulse_period,
    input  logic [NUM_W-1:0] i_pulse_count,
    output logic [CH-1:0]    o_pulse_out,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

    state_e           r_state;
    logic [CH-1:0]    r_mask;
    logic [CH-1:0]    r_pulse_out;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_low_len;
    logic [CNT_W-1:0] r_phase_cnt;
    logic [NUM_W-1:0] r_remain;
    logic             r_busy;
    logic             r_done;

    logic [CNT_W:0]   w_low_diff;
    logic [CNT_W-1:0] w_low_len;
    logic             w_cfg_empty;
    logic             w_last_tick;

    // One extra bit: a borrow or a zero result both mean period <= width.
    assign w_low_diff  = {1'b0, i_pulse_period} - {1'b0, i_pulse_width};
    assign w_low_len   = (w_low_diff[CNT_W] || (w_low_diff == '0)) ?
                         CNT_W'(1) : w_low_diff[CNT_W-1:0];
    assign w_cfg_empty = (i_pulse_width == '0) || (i_pulse_count == '0);
    assign w_last_tick = (r_phase_cnt == CNT_W'(1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_mask      <= '0;
            r_pulse_out <= '0;
            r_width     <= '0;
            r_low_len   <= '0;
            r_phase_cnt <= '0;
            r_remain    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (i_abort && (r_state != StIdle)) begin
            r_state     <= StIdle;
            r_pulse_out <= '0;
            r_phase_cnt <= '0;
            r_remain    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (i_start && !i_abort) begin
                        r_mask    <= i_chan_mask;
                        r_width   <= i_pulse_width;
                        r_low_len <= w_low_len;
                        r_busy    <= 1'b1;
                        if (w_cfg_empty) begin
                            r_state     <= StDone;
                            r_done      <= 1'b1;
                            r_pulse_out <= '0;
                            r_phase_cnt <= '0;
                            r_remain    <= '0;
                        end else begin
                            r_state     <= StHigh;
                            r_pulse_out <= i_chan_mask;
                            r_phase_cnt <= i_pulse_width;
                            r_remain    <= i_pulse_count;
                        end
                    end
                end
                StHigh: begin
                    if (w_last_tick) begin
                        r_pulse_out <= '0;
                        r_remain    <= r_remain - NUM_W'(1);
                        if (r_remain == NUM_W'(1)) begin
                            // Final pulse: no trailing low phase.
                            r_state     <= StDone;
                            r_done      <= 1'b1;
                            r_phase_cnt <= '0;
                        end else begin
                            r_state     <= StLow;
                            r_phase_cnt <= r_low_len;
                        end
                    end else begin
                        r_phase_cnt <= r_phase_cnt - CNT_W'(1);
                    end
                end
                StLow: begin
                    if (w_last_tick) begin
                        r_state     <= StHigh;
                        r_pulse_out <= r_mask;
                        r_phase_cnt <= r_width;
                    end else begin
                        r_phase_cnt <= r_phase_cnt - CNT_W'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state     <= StIdle;
                    r_pulse_out <= '0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign o_pulse_out = r_pulse_out;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: an arithmetic burst model checked every cycle, plus
// literal per-test totals that pin both the model and the design.
module tb_pulse_train_gen;

    localparam int unsigned CH    = 32;
    localparam int unsigned CNT_W = 22;
    localparam int unsigned NUM_W = 16;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic [CH-1:0]    i_chan_mask = '0;
    logic [CNT_W-1:0] i_pulse_width = '0;
    logic [CNT_W-1:0] i_pulse_period = '0;
    logic [NUM_W-1:0] i_pulse_count = '0;
    logic [CH-1:0]    o_pulse_out;
    logic             o_busy;
    logic             o_done;

    pulse_train_gen #(.CH(CH), .CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_chan_mask    (i_chan_mask),
        .i_pulse_width  (i_pulse_width),
        .i_pulse_period (i_pulse_period),
        .i_pulse_count  (i_pulse_count),
        .o_pulse_out    (o_pulse_out),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #25 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: a burst is its start edge plus latched config; outputs follow from
    // the elapsed edge count t by plain arithmetic.
    longint        m_n = 0;
    bit            m_active = 1'b0;
    longint        m_s = 0;
    logic [CH-1:0] m_mask = '0;
    longint        m_w = 0;
    longint        m_low = 0;
    longint        m_cnt = 0;

    function automatic longint m_end_t();
        if (m_w == 0 || m_cnt == 0) return 0;
        return m_cnt * m_w + (m_cnt - 1) * m_low;
    endfunction

    function automatic void m_expect(input longint n, output logic [CH-1:0] p,
                                     output logic b, output logic d);
        longint t;
        p = '0;
        b = 1'b0;
        d = 1'b0;
        if (!m_active || n < m_s) return;
        t = n - m_s;
        if (t > m_end_t()) return;
        b = 1'b1;
        if (t == m_end_t()) begin
            d = 1'b1;
            return;
        end
        if ((t % (m_w + m_low)) < m_w) p = m_mask;
    endfunction

    always @(posedge i_clk) begin : model_upd
        logic [CH-1:0] p;
        logic          b;
        logic          d;
        m_expect(m_n, p, b, d);
        if (!i_rst_n) begin
            m_active <= 1'b0;
        end else if (b && i_abort) begin
            m_active <= 1'b0;
        end else if (!b && i_start && !i_abort) begin
            m_active <= 1'b1;
            m_s      <= m_n + 1;
            m_mask   <= i_chan_mask;
            m_w      <= longint'(i_pulse_width);
            m_low    <= (i_pulse_period > i_pulse_width) ?
                        longint'(i_pulse_period) - longint'(i_pulse_width) : 1;
            m_cnt    <= longint'(i_pulse_count);
        end
        m_n <= m_n + 1;
    end

    longint        n_busy = 0, n_hi = 0, n_done = 0;
    longint        mb_c = 0, mh_c = 0, md_c = 0;
    longint        last_rise = 0, rise_gap = 0;
    logic [CH-1:0] prev_out = '0;

    always @(negedge i_clk) begin : compare
        logic [CH-1:0] p;
        logic          b;
        logic          d;
        if (chk_en) begin
            m_expect(m_n, p, b, d);
            check("pulse_out", 64'(o_pulse_out), 64'(p));
            check("busy", 64'(o_busy), 64'(b));
            check("done", 64'(o_done), 64'(d));
            if (o_busy === 1'b1) n_busy <= n_busy + 1;
            if (o_pulse_out != '0) n_hi <= n_hi + 1;
            if (o_done === 1'b1) n_done <= n_done + 1;
            if (b) mb_c <= mb_c + 1;
            if (p != '0) mh_c <= mh_c + 1;
            if (d) md_c <= md_c + 1;
            if (o_pulse_out != '0 && prev_out == '0) begin
                rise_gap  <= m_n - last_rise;
                last_rise <= m_n;
            end
            prev_out <= o_pulse_out;
        end
    end

    longint s_busy, s_hi, s_done, s_mb, s_mh, s_md;

    task automatic snap();
        s_busy = n_busy; s_hi = n_hi; s_done = n_done;
        s_mb = mb_c; s_mh = mh_c; s_md = md_c;
    endtask

    task automatic stat_check(input string tag, input longint eb, input longint eh,
                              input longint ed);
        check({tag, "_busy_cycles"}, 64'(n_busy - s_busy), 64'(eb));
        check({tag, "_high_cycles"}, 64'(n_hi - s_hi), 64'(eh));
        check({tag, "_done_count"}, 64'(n_done - s_done), 64'(ed));
        check({tag, "_model_busy"}, 64'(mb_c - s_mb), 64'(eb));
        check({tag, "_model_high"}, 64'(mh_c - s_mh), 64'(eh));
        check({tag, "_model_done"}, 64'(md_c - s_md), 64'(ed));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic set_cfg(input logic [CH-1:0] mask, input int unsigned w,
                           input int unsigned p, input int unsigned c);
        i_chan_mask    = mask;
        i_pulse_width  = CNT_W'(w);
        i_pulse_period = CNT_W'(p);
        i_pulse_count  = NUM_W'(c);
    endtask

    task automatic do_start(input logic [CH-1:0] mask, input int unsigned w,
                            input int unsigned p, input int unsigned c);
        set_cfg(mask, w, p, c);
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (o_busy === 1'b0) break;
            cyc(1);
        end
        if (k >= budget) check({tag, "_timeout"}, 64'(1), 64'(0));
        cyc(2);
    endtask

    initial begin
        cyc(2);
        check("reset_pulse_out", 64'(o_pulse_out), 64'(0));
        check("reset_busy", 64'(o_busy), 64'(0));
        check("reset_done", 64'(o_done), 64'(0));
        chk_en  = 1'b1;
        i_rst_n = 1'b1;
        cyc(2);

        // 1: single 2-cycle pulse
        snap();
        do_start(32'h1, 2, 10, 1);
        check("t1_first_cycle", 64'(o_pulse_out), 64'h1);
        wait_idle("t1", 50);
        stat_check("t1", 3, 2, 1);

        // 2: three 4-cycle pulses, 8-cycle period
        snap();
        do_start(32'h2, 4, 8, 3);
        wait_idle("t2", 100);
        stat_check("t2", 21, 12, 1);
        check("t2_rise_gap", 64'(rise_gap), 64'(8));

        // 3: period below width gives a single low cycle
        snap();
        do_start(32'hFFFF_FFFF, 6, 3, 2);
        check("t3_first_cycle", 64'(o_pulse_out), 64'hFFFF_FFFF);
        wait_idle("t3", 100);
        stat_check("t3", 14, 12, 1);
        check("t3_rise_gap", 64'(rise_gap), 64'(7));

        // 4a: restart and width change while busy are ignored
        snap();
        do_start(32'h8, 4, 8, 3);
        cyc(1);
        set_cfg(32'h1, 1, 2, 1);
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        i_pulse_width = CNT_W'(9);
        wait_idle("t4a", 100);
        stat_check("t4a", 21, 12, 1);
        check("t4a_rise_gap", 64'(rise_gap), 64'(8));

        // 4b: abort during the low phase after pulse 2 of 5
        snap();
        do_start(32'h10, 3, 5, 5);
        cyc(8);
        i_abort = 1'b1;
        cyc(1);
        i_abort = 1'b0;
        check("t4b_abort_busy", 64'(o_busy), 64'(0));
        check("t4b_abort_out", 64'(o_pulse_out), 64'(0));
        cyc(5);
        stat_check("t4b", 9, 6, 0);

        // 5: degenerate configurations
        snap();
        do_start(32'h3, 4, 8, 0);
        wait_idle("t5a", 20);
        stat_check("t5a", 1, 0, 1);
        snap();
        do_start(32'h3, 0, 8, 2);
        wait_idle("t5b", 20);
        stat_check("t5b", 1, 0, 1);
        snap();
        set_cfg(32'h3, 4, 8, 2);
        i_start = 1'b1;
        i_abort = 1'b1;
        cyc(1);
        i_start = 1'b0;
        i_abort = 1'b0;
        cyc(4);
        stat_check("t5c", 0, 0, 0);

        // 6: reset mid-pulse, then a clean 100-cycle pulse
        snap();
        do_start(32'h5, 100, 200, 1);
        cyc(10);
        i_rst_n = 1'b0;
        cyc(1);
        check("t6_rst_out", 64'(o_pulse_out), 64'(0));
        check("t6_rst_busy", 64'(o_busy), 64'(0));
        i_rst_n = 1'b1;
        cyc(2);
        stat_check("t6_cut", 11, 11, 0);
        snap();
        do_start(32'h5, 100, 200, 1);
        check("t6_first_cycle", 64'(o_pulse_out), 64'h5);
        wait_idle("t6", 300);
        stat_check("t6", 101, 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- 32-channel programmable pulse-train generator; the transmit-side counterpart of the pulse filter.
- Emits bursts of clean pulses with a programmable width, period and count on selected channels.
- Used to drive the filter's pulse inputs, and board pulse outputs, with known-width pulses.
- Widths are in clock cycles, the same unit as the filter coefficient. A 4-cycle pulse therefore exactly meets a filter coefficient of 4.

Parameters:
CH, 32, number of pulse output channels
CNT_W, 22, width of the pulse width and period fields (clock cycles)
NUM_W, 16, width of the pulse count field

Ports:
clk  input  1  system clock (20 MHz, 50 ns period, in the target system)
rst_n  input  1  reset; synchronous and active-low
start  input  1  one-cycle request to begin a burst; honoured only in IDLE
abort  input  1  terminate the burst immediately
chan_mask  input  CH  channels that carry the burst (1 = pulsed)
pulse_width  input  CNT_W  high time per pulse, in clocks
pulse_period  input  CNT_W  rising-edge-to-rising-edge spacing, in clocks
pulse_count  input  NUM_W  number of pulses in the burst
pulse_out  output  CH  registered pulse outputs
busy  output  1  burst in progress
done  output  1  one-cycle strobe at normal burst completion

Behaviour:
- All state changes on rising clk. Reset takes effect when rst_n = 0 at a clk edge.
- Reset values: pulse_out = 0, busy = 0, done = 0, FSM = IDLE, all counters = 0.
- Reset mid-burst clears outputs on that edge. No done strobe is issued.
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE, start = 1, abort = 0:
  - Latch chan_mask, pulse_width, pulse_period and pulse_count.
  - Load the width counter and the remaining-pulse counter.
  - Go to HIGH.
- IDLE, start = 1, but latched width = 0 or count = 0: go straight to DONE. No pulses are emitted.
- Config latching: latched values are used for the whole burst. Input changes while busy have no effect.
- Latency: start sampled at edge k → pulse_out = latched mask from edge k+1.
- HIGH:
  - pulse_out = latched mask for exactly pulse_width cycles.
  - On expiry, decrement the remaining-pulse count.
  - If remaining = 0, go to DONE; else go to LOW.
- LOW:
  - pulse_out = 0 for low_len = pulse_period − pulse_width cycles, then go to HIGH.
  - If pulse_period ≤ pulse_width, low_len = 1. Pulses are always separated by at least one low cycle.
- DONE:
  - pulse_out = 0, done = 1 for exactly one cycle, then go to IDLE.
  - No trailing low phase after the final pulse.
- busy = 1 in HIGH, LOW and DONE; 0 in IDLE. busy is registered and rises on the same edge as pulse_out.
- start while busy is ignored and is not queued.
- abort = 1 in any non-IDLE state:
  - Next edge: pulse_out = 0, busy = 0, FSM = IDLE, done stays 0.
- abort and start together in IDLE: abort wins and start is ignored.
- Counter rules:
  - All counters are unsigned and never wrap.
  - Maximum width is 2^CNT_W − 1 cycles; maximum count is 2^NUM_W − 1.
  - low_len subtraction is done at CNT_W+1 bits so the period ≤ width test is exact.
- Mask handling:
  - Channels with mask = 0 stay 0 throughout.
  - A mask of all zeros still runs the full timing (busy and done behave normally).

Test Plan:
1. Reset, then start with mask = 0x1, width = 2, period = 10, count = 1.
   - Required: pulse_out[0] high for 2 cycles (100 ns), beginning the cycle after start.
   - Required: done the cycle after the pulse falls; busy spans 3 cycles.
   - Through the filter at coeff 4, the output stays 0.
2. Mask = 0x2, width = 4, period = 8, count = 3.
   - Required: three 4-cycle pulses on bit 1 with rising edges 8 cycles apart; done once; total busy = 21 cycles.
   - Through the filter at coeff 4, all three pulses pass.
3. width = 6, period = 3, count = 2, mask = 0xFFFFFFFF.
   - Required: all bits high 6 cycles, low exactly 1 cycle, high 6 cycles, then done.
4. Mid-burst events.
   - Assert start again during HIGH: ignored.
   - Change pulse_width while busy: burst unchanged.
   - Assert abort during LOW of pulse 2 of 5: pulse_out = 0 and busy = 0 next cycle, done never pulses.
5. Degenerate configs.
   - count = 0, or width = 0, with start: pulse_out stays 0, busy = 1 for one cycle, done pulses once.
   - start + abort in the same IDLE cycle: nothing happens.
6. Drive rst_n = 0 for one cycle during HIGH of a burst (mask = 0x5, width = 100).
   - Required: outputs 0 at that edge and FSM in IDLE.
   - Required: a new start afterwards produces a correct 100-cycle pulse on bits 0 and 2.
